// File: rtl/batter_result_ctrl.sv
// rtl/batter_result_ctrl.sv - at-bat result sequencer and game-state keeper for the batter display
module batter_result_ctrl #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int RUN_MAX     = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       res_valid,
    input  logic [2:0] res_code,
    output logic       res_ready,
    output logic [4:0] hitout,
    output logic [2:0] bases,
    output logic [1:0] outs,
    output logic [6:0] runs,
    output logic       change_side,
    output logic       bad_code
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [2:0] CODE_OUT = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_ADVANCE,
        S_CHANGE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    code_q, code_d;
    logic [2:0]    bases_q, bases_d;
    logic [1:0]    outs_q, outs_d;
    logic [6:0]    runs_q, runs_d;
    logic          bad_q, bad_d;

    logic [6:0]    b4;
    logic [2:0]    scored;
    logic [7:0]    run_sum;
    logic          code_ok;

    // State register; new_game clears everything exactly like reset
    always_ff @(posedge clk) begin
        if (!rst_n || new_game) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            bases_q <= '0;
            outs_q  <= '0;
            runs_q  <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            bases_q <= bases_d;
            outs_q  <= outs_d;
            runs_q  <= runs_d;
            bad_q   <= bad_d;
        end
    end

    // Next-state logic: handshake, hold timing and the runner/run/out bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        bases_d = bases_q;
        outs_d  = outs_q;
        runs_d  = runs_q;
        bad_d   = 1'b0;
        code_ok = (res_code >= 3'd1) && (res_code <= 3'd5);
        // Batter lands at bit N-1 and each runner moves N bases; bits 3 and up have crossed home
        b4      = ({3'b000, bases_q, 1'b0} << (code_q - 3'd1)) | (7'd1 << (code_q - 3'd1));
        scored  = 3'(b4[3]) + 3'(b4[4]) + 3'(b4[5]) + 3'(b4[6]);
        run_sum = {1'b0, runs_q} + {5'b00000, scored};
        case (state_q)
            S_IDLE: begin
                if (res_valid) begin
                    if (code_ok) begin
                        code_d  = res_code;
                        cnt_d   = '0;
                        state_d = S_SHOW;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            S_SHOW: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_ADVANCE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ADVANCE: begin
                if (code_q == CODE_OUT) begin
                    if (outs_q == 2'd2) begin
                        outs_d  = '0;
                        bases_d = '0;
                        cnt_d   = '0;
                        state_d = S_CHANGE;
                    end else begin
                        outs_d  = outs_q + 2'd1;
                        state_d = S_IDLE;
                    end
                end else begin
                    bases_d = b4[2:0];
                    runs_d  = (run_sum > 8'(RUN_MAX)) ? 7'(RUN_MAX) : run_sum[6:0];
                    state_d = S_IDLE;
                end
            end
            S_CHANGE: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded purely from registered state
    always_comb begin
        res_ready   = (state_q == S_IDLE);
        hitout      = (state_q == S_SHOW) ? (5'b10000 >> (code_q - 3'd1)) : 5'b00000;
        change_side = (state_q == S_CHANGE) && (cnt_q == LAST);
        bases       = bases_q;
        outs        = outs_q;
        runs        = runs_q;
        bad_code    = bad_q;
    end

endmodule

// File: tb/tb_batter_result_ctrl.sv
// tb/tb_batter_result_ctrl.sv - self-checking bench for batter_result_ctrl
module tb_batter_result_ctrl;

    localparam int HOLD = 4;
    localparam int RMAX = 99;

    logic       clk = 1'b0;
    logic       rst_n, new_game, res_valid;
    logic [2:0] res_code;
    logic       res_ready, change_side, bad_code;
    logic [4:0] hitout;
    logic [2:0] bases;
    logic [1:0] outs;
    logic [6:0] runs;

    int n_total = 0;
    int n_pass  = 0;

    // reference game state: which bases hold a runner, outs, runs
    bit [2:0] m_bases;
    int       m_outs, m_runs;
    bit       m_chg;

    typedef struct {
        logic [2:0] code;
        logic [2:0] eb;
        logic [1:0] eo;
        int         er;
        bit         ec;
    } vec_t;
    vec_t tbl[16];

    batter_result_ctrl #(.HOLD_CYCLES(HOLD), .RUN_MAX(RMAX)) dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game),
        .res_valid(res_valid), .res_code(res_code), .res_ready(res_ready),
        .hitout(hitout), .bases(bases), .outs(outs), .runs(runs),
        .change_side(change_side), .bad_code(bad_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_bases = '0; m_outs = 0; m_runs = 0; m_chg = 0;
    endtask

    // Baseball rules: every runner moves N bases, batter reaches base N, reaching 4 scores
    task automatic model_apply(input int code);
        bit [2:0] nb;
        int scored, p;
        m_chg = 0;
        if (code >= 1 && code <= 4) begin
            nb = '0;
            scored = 0;
            for (int b = 1; b <= 3; b++) begin
                if (m_bases[b-1]) begin
                    p = b + code;
                    if (p >= 4) scored++;
                    else nb[p-1] = 1'b1;
                end
            end
            if (code == 4) scored++;
            else nb[code-1] = 1'b1;
            m_bases = nb;
            m_runs = (m_runs + scored > RMAX) ? RMAX : m_runs + scored;
        end else if (code == 5) begin
            m_outs++;
            if (m_outs == 3) begin
                m_outs = 0;
                m_bases = '0;
                m_chg = 1;
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_hitout"}, hitout, 0);
        chk({tag, "_bases"}, bases, 0);
        chk({tag, "_outs"}, outs, 0);
        chk({tag, "_runs"}, runs, 0);
        chk({tag, "_ready"}, res_ready, 1);
        chk({tag, "_change"}, change_side, 0);
        chk({tag, "_bad"}, bad_code, 0);
    endtask

    // Offers one code and follows it through its whole timeline; ends in the next IDLE cycle
    task automatic atbat(input logic [2:0] code, input logic [2:0] eb, input logic [1:0] eo,
                         input int er, input bit ec);
        int oh;
        @(negedge clk);
        chk("ready_before", res_ready, 1);
        res_valid = 1'b1;
        res_code  = code;
        @(negedge clk);
        res_valid = 1'b0;
        res_code  = 3'($urandom);
        if (code == 0 || code > 5) begin
            chk("bad_pulse", bad_code, 1);
            chk("bad_ready", res_ready, 1);
            chk("bad_hitout", hitout, 0);
            chk("bad_bases", bases, eb);
            chk("bad_runs", runs, er);
            @(negedge clk);
            chk("bad_pulse_end", bad_code, 0);
            chk("bad_outs", outs, eo);
            return;
        end
        oh = 1 << (5 - code);
        for (int i = 0; i < HOLD; i++) begin
            chk("show_hitout", hitout, oh);
            chk("show_ready", res_ready, 0);
            res_valid = 1'($urandom);
            res_code  = 3'($urandom);
            @(negedge clk);
        end
        res_valid = 1'b0;
        chk("adv_hitout", hitout, 0);
        chk("adv_ready", res_ready, 0);
        @(negedge clk);
        if (ec) begin
            chk("chg_outs", outs, 0);
            chk("chg_bases", bases, 0);
            for (int i = 0; i < HOLD; i++) begin
                chk("chg_ready", res_ready, 0);
                chk("chg_hitout", hitout, 0);
                chk("chg_pulse", change_side, (i == HOLD - 1) ? 1 : 0);
                res_valid = 1'($urandom);
                @(negedge clk);
            end
            res_valid = 1'b0;
        end
        chk("end_ready", res_ready, 1);
        chk("end_bases", bases, eb);
        chk("end_outs", outs, eo);
        chk("end_runs", runs, er);
        chk("end_change", change_side, 0);
        chk("end_hitout", hitout, 0);
    endtask

    task automatic atbat_m(input int code);
        model_apply(code);
        atbat(3'(code), m_bases, 2'(m_outs), m_runs, m_chg);
    endtask

    initial begin
        int r, c;
        tbl[0]  = '{3'd2, 3'b010, 2'd0, 0, 1'b0};
        tbl[1]  = '{3'd1, 3'b101, 2'd0, 0, 1'b0};
        tbl[2]  = '{3'd1, 3'b011, 2'd0, 1, 1'b0};
        tbl[3]  = '{3'd1, 3'b111, 2'd0, 1, 1'b0};
        tbl[4]  = '{3'd4, 3'b000, 2'd0, 5, 1'b0};
        tbl[5]  = '{3'd5, 3'b000, 2'd1, 5, 1'b0};
        tbl[6]  = '{3'd2, 3'b010, 2'd1, 5, 1'b0};
        tbl[7]  = '{3'd3, 3'b100, 2'd1, 6, 1'b0};
        tbl[8]  = '{3'd5, 3'b100, 2'd2, 6, 1'b0};
        tbl[9]  = '{3'd1, 3'b001, 2'd2, 7, 1'b0};
        tbl[10] = '{3'd1, 3'b011, 2'd2, 7, 1'b0};
        tbl[11] = '{3'd2, 3'b110, 2'd2, 8, 1'b0};
        tbl[12] = '{3'd5, 3'b000, 2'd0, 8, 1'b1};
        tbl[13] = '{3'd6, 3'b000, 2'd0, 8, 1'b0};
        tbl[14] = '{3'd0, 3'b000, 2'd0, 8, 1'b0};
        tbl[15] = '{3'd7, 3'b000, 2'd0, 8, 1'b0};

        rst_n = 1'b0; new_game = 1'b0; res_valid = 1'b0; res_code = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_cleared("reset");
        model_reset();

        for (int i = 0; i < 16; i++) begin
            atbat(tbl[i].code, tbl[i].eb, tbl[i].eo, tbl[i].er, tbl[i].ec);
            model_apply(int'(tbl[i].code));
        end

        // new_game while the change-side blank is being held
        atbat_m(5);
        atbat_m(5);
        @(negedge clk);
        res_valid = 1'b1; res_code = 3'd5;
        @(negedge clk);
        res_valid = 1'b0;
        repeat (HOLD + 1) @(negedge clk);
        chk("ng_in_change_outs", outs, 0);
        chk("ng_in_change_ready", res_ready, 0);
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check_cleared("newgame_change");
        for (int i = 0; i < HOLD + 2; i++) begin
            chk("ng_no_pulse", change_side, 0);
            @(negedge clk);
        end
        model_reset();

        // reset in the middle of a SHOW hold
        atbat_m(2);
        @(negedge clk);
        res_valid = 1'b1; res_code = 3'd3;
        @(negedge clk);
        res_valid = 1'b0;
        chk("rst_show_hitout", hitout, 5'b00100);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_cleared("reset_show");
        repeat (HOLD + 2) @(negedge clk);
        chk("rst_show_stays_idle", hitout, 0);
        chk("rst_show_bases", bases, 0);
        model_reset();

        // new_game beats a concurrent offer
        atbat_m(1);
        @(negedge clk);
        new_game = 1'b1; res_valid = 1'b1; res_code = 3'd4;
        @(negedge clk);
        new_game = 1'b0; res_valid = 1'b0;
        check_cleared("newgame_offer");
        @(negedge clk);
        chk("ng_offer_hitout", hitout, 0);
        model_reset();

        // drive runs to 98 with bases loaded, then grand slams at the saturation limit
        repeat (98) atbat_m(4);
        repeat (3) atbat_m(1);
        chk("pre_sat_runs", runs, 98);
        atbat_m(4);
        chk("sat_runs", runs, RMAX);
        repeat (3) atbat_m(1);
        atbat_m(4);
        atbat_m(6);

        // randomized at-bats against the reference model
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) c = r + 1;
            else if (r < 8) c = 5;
            else if (r == 8) c = 6;
            else c = ($urandom_range(0, 1) == 0) ? 0 : 7;
            atbat_m(c);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
